// File: rtl/hardwired_control_unit.sv
// Hardwired Mini-SRC control sequencer: fetch, decode IR[31:27],
// walk the per-opcode T-states and emit registered datapath strobes.
module hardwired_control_unit #(
  parameter int MEM_RD_CYCLES = 1,
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        CONin,
  output logic        OUT_Portin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        IncPC,
  output logic        Read,
  output logic        read_mem,
  output logic        write_mem,
  output logic        PCSave,
  output logic        CON_RESET,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    K_NOP, K_HALT, K_RT, K_NEGNOT,
    K_IMM, K_MULDIV, K_LDI, K_LD,
    K_ST, K_BR, K_JR, K_JAL,
    K_IN, K_OUT, K_MFHI, K_MFLO
  } kind_e;

  typedef struct packed {
    logic HIout;
    logic LOout;
    logic Zhighout;
    logic Zlowout;
    logic PCout;
    logic MDRout;
    logic INout;
    logic Cout;
    logic BAout;
    logic Rout;
    logic HIin;
    logic LOin;
    logic PCin;
    logic IRin;
    logic Zin;
    logic Yin;
    logic MARin;
    logic MDRin;
    logic CONin;
    logic OUT_Portin;
    logic Rin;
    logic Gra;
    logic Grb;
    logic Grc;
    logic AND;
    logic OR;
    logic ADD;
    logic SUB;
    logic MUL;
    logic DIV;
    logic SHR;
    logic SHRA;
    logic SHL;
    logic ROR;
    logic ROL;
    logic NEG;
    logic NOT;
    logic IncPC;
    logic Read;
    logic read_mem;
    logic write_mem;
    logic PCSave;
    logic CON_RESET;
    logic run;
  } ctl_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(7);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(8);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(9);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(10);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_BR   = OPW'(19);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
  localparam logic [OPW-1:0] OP_IN   = OPW'(22);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  localparam logic [2:0] CNT_MAX = 3'(MEM_RD_CYCLES - 1);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [2:0]     cnt_q, cnt_d;
  ctl_t           ctl_q, ctl_d;
  kind_e          kind_q, kind_ir;
  logic           unused_ir;

  assign unused_ir = ^IR[31-OPW:0];

  function automatic kind_e classify(logic [OPW-1:0] op);
    kind_e k;
    unique case (1'b1)
      op == OP_LD:   k = K_LD;
      op == OP_LDI:  k = K_LDI;
      op == OP_ST:   k = K_ST;
      (op >= OP_ADD) && (op <= OP_SHL):
        k = K_RT;
      (op >= OP_ADDI) && (op <= OP_ORI):
        k = K_IMM;
      (op == OP_DIV) || (op == OP_MUL):
        k = K_MULDIV;
      (op == OP_NEG) || (op == OP_NOT):
        k = K_NEGNOT;
      op == OP_BR:   k = K_BR;
      op == OP_JR:   k = K_JR;
      op == OP_JAL:  k = K_JAL;
      op == OP_IN:   k = K_IN;
      op == OP_OUT:  k = K_OUT;
      op == OP_MFHI: k = K_MFHI;
      op == OP_MFLO: k = K_MFLO;
      op == OP_HALT: k = K_HALT;
      default:       k = K_NOP;
    endcase
    return k;
  endfunction

  function automatic ctl_t with_alu(ctl_t ci, logic [OPW-1:0] op);
    ctl_t c;
    c = ci;
    case (op)
      OP_ADD, OP_ADDI: c.ADD = 1'b1;
      OP_AND, OP_ANDI: c.AND = 1'b1;
      OP_OR, OP_ORI:   c.OR = 1'b1;
      OP_SUB:  c.SUB = 1'b1;
      OP_ROR:  c.ROR = 1'b1;
      OP_ROL:  c.ROL = 1'b1;
      OP_SHR:  c.SHR = 1'b1;
      OP_SHRA: c.SHRA = 1'b1;
      OP_SHL:  c.SHL = 1'b1;
      OP_DIV:  c.DIV = 1'b1;
      OP_MUL:  c.MUL = 1'b1;
      OP_NEG:  c.NEG = 1'b1;
      OP_NOT:  c.NOT = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic state_e last_of(kind_e k);
    state_e s;
    unique case (k)
      K_RT, K_IMM, K_LDI: s = S_T5;
      K_NEGNOT, K_JAL:    s = S_T4;
      K_MULDIV, K_BR:     s = S_T6;
      K_LD, K_ST:         s = S_T7;
      default:            s = S_T3;
    endcase
    return s;
  endfunction

  function automatic state_e step(state_e s);
    state_e n;
    unique case (s)
      S_T3:    n = S_T4;
      S_T4:    n = S_T5;
      S_T5:    n = S_T6;
      S_T6:    n = S_T7;
      default: n = S_T0;
    endcase
    return n;
  endfunction

  function automatic logic is_mem(state_e s, kind_e k);
    return (s == S_T1) ||
           ((s == S_T6) && (k == K_LD)) ||
           ((s == S_T7) && (k == K_ST));
  endfunction

  function automatic ctl_t decode(state_e s,
                                  logic [OPW-1:0] op,
                                  logic con);
    ctl_t  c;
    kind_e k;
    c = '0;
    k = classify(op);
    c.run = (s != S_RST) && (s != S_HALT);
    unique case (s)
      S_RST: c.CON_RESET = 1'b1;
      S_T0: begin
        c.IncPC = 1'b1; c.MARin = 1'b1; c.PCin = 1'b1;
      end
      S_T1: begin
        c.Read = 1'b1; c.read_mem = 1'b1; c.MDRin = 1'b1;
      end
      S_T2: begin
        c.Read = 1'b1; c.MDRout = 1'b1; c.IRin = 1'b1;
      end
      S_T3: begin
        unique case (k)
          K_RT, K_IMM: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1;
          end
          K_NEGNOT: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1;
            c = with_alu(c, op);
          end
          K_MULDIV: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1;
          end
          K_LDI, K_LD, K_ST: begin
            c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1;
          end
          K_BR: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1;
          end
          K_JR: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1;
          end
          K_JAL: begin
            c.PCSave = 1'b1; c.PCout = 1'b1; c.Rin = 1'b1;
          end
          K_IN: begin
            c.INout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          K_OUT: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.OUT_Portin = 1'b1;
          end
          K_MFHI: begin
            c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          K_MFLO: begin
            c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (k)
          K_RT: begin
            c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1;
            c = with_alu(c, op);
          end
          K_NEGNOT: begin
            c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          K_IMM: begin
            c.Cout = 1'b1; c.Zin = 1'b1;
            c = with_alu(c, op);
          end
          K_MULDIV: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1;
            c = with_alu(c, op);
          end
          K_LDI, K_LD, K_ST: begin
            c.Cout = 1'b1; c.ADD = 1'b1; c.Zin = 1'b1;
          end
          K_BR: begin
            c.PCout = 1'b1; c.Yin = 1'b1;
          end
          K_JAL: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (k)
          K_RT, K_IMM, K_LDI: begin
            c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          K_MULDIV: begin
            c.Zlowout = 1'b1; c.LOin = 1'b1;
          end
          K_LD, K_ST: begin
            c.Zlowout = 1'b1; c.MARin = 1'b1;
          end
          K_BR: begin
            c.Cout = 1'b1; c.ADD = 1'b1; c.Zin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (k)
          K_MULDIV: begin
            c.Zhighout = 1'b1; c.HIin = 1'b1;
          end
          K_LD: begin
            c.Read = 1'b1; c.read_mem = 1'b1; c.MDRin = 1'b1;
          end
          K_ST: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1;
          end
          K_BR: begin
            c.Zlowout = con; c.PCin = con;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (k)
          K_LD: begin
            c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          K_ST: c.write_mem = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

  assign kind_q  = classify(op_q);
  assign kind_ir = classify(IR[31 -: OPW]);

  // Memory states hold until the wait counter saturates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = '0;
    if (is_mem(state_q, kind_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      unique case (state_q)
        S_RST:  state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1:   state_d = S_T2;
        S_T2: begin
          op_d = IR[31 -: OPW];
          unique case (kind_ir)
            K_NOP:   state_d = S_T0;
            K_HALT:  state_d = S_HALT;
            default: state_d = S_T3;
          endcase
        end
        S_HALT: state_d = S_HALT;
        default: begin
          if (state_q == last_of(kind_q))
            state_d = S_T0;
          else
            state_d = step(state_q);
        end
      endcase
    end
  end

  assign ctl_d = decode(state_d, op_d, CON_FF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      op_q    <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      ctl_q.CON_RESET <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign {HIout, LOout, Zhighout, Zlowout, PCout,
          MDRout, INout, Cout, BAout, Rout,
          HIin, LOin, PCin, IRin, Zin, Yin,
          MARin, MDRin, CONin, OUT_Portin, Rin,
          Gra, Grb, Grc,
          AND, OR, ADD, SUB, MUL, DIV, SHR,
          SHRA, SHL, ROR, ROL, NEG, NOT,
          IncPC, Read, read_mem, write_mem,
          PCSave, CON_RESET, run} = ctl_q;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Bench for hardwired_control_unit: two instances (1 and 3 wait
// cycles) checked against a per-opcode strobe-sequence table.
`timescale 1ns/1ps
module tb_hardwired_control_unit;

  typedef logic [43:0] vec_t;

  localparam int HIOUT = 0, LOOUT = 1, ZHIOUT = 2, ZLOOUT = 3;
  localparam int PCOUT = 4, MDROUT = 5, INOUT = 6, COUT = 7;
  localparam int BAOUT = 8, ROUT = 9, HIIN = 10, LOIN = 11;
  localparam int PCIN = 12, IRIN = 13, ZIN = 14, YIN = 15;
  localparam int MARIN = 16, MDRIN = 17, CONIN = 18;
  localparam int OUTPIN = 19, RIN = 20;
  localparam int GRA = 21, GRB = 22, GRC = 23;
  localparam int A_AND = 24, A_OR = 25, A_ADD = 26, A_SUB = 27;
  localparam int A_MUL = 28, A_DIV = 29, A_SHR = 30;
  localparam int A_SHRA = 31, A_SHL = 32, A_ROR = 33;
  localparam int A_ROL = 34, A_NEG = 35, A_NOT = 36;
  localparam int INCPC = 37, READ = 38, RDMEM = 39, WRMEM = 40;
  localparam int PCSAVE = 41, CONRST = 42, RUN = 43;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir [2];
  logic        con [2];
  vec_t        o0, o1;
  vec_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vec_t ov;
    hardwired_control_unit #(
      .MEM_RD_CYCLES(g == 0 ? 1 : 3),
      .OPW(5)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .IR(ir[g]),
      .CON_FF(con[g]),
      .HIout(ov[HIOUT]),
      .LOout(ov[LOOUT]),
      .Zhighout(ov[ZHIOUT]),
      .Zlowout(ov[ZLOOUT]),
      .PCout(ov[PCOUT]),
      .MDRout(ov[MDROUT]),
      .INout(ov[INOUT]),
      .Cout(ov[COUT]),
      .BAout(ov[BAOUT]),
      .Rout(ov[ROUT]),
      .HIin(ov[HIIN]),
      .LOin(ov[LOIN]),
      .PCin(ov[PCIN]),
      .IRin(ov[IRIN]),
      .Zin(ov[ZIN]),
      .Yin(ov[YIN]),
      .MARin(ov[MARIN]),
      .MDRin(ov[MDRIN]),
      .CONin(ov[CONIN]),
      .OUT_Portin(ov[OUTPIN]),
      .Rin(ov[RIN]),
      .Gra(ov[GRA]),
      .Grb(ov[GRB]),
      .Grc(ov[GRC]),
      .AND(ov[A_AND]),
      .OR(ov[A_OR]),
      .ADD(ov[A_ADD]),
      .SUB(ov[A_SUB]),
      .MUL(ov[A_MUL]),
      .DIV(ov[A_DIV]),
      .SHR(ov[A_SHR]),
      .SHRA(ov[A_SHRA]),
      .SHL(ov[A_SHL]),
      .ROR(ov[A_ROR]),
      .ROL(ov[A_ROL]),
      .NEG(ov[A_NEG]),
      .NOT(ov[A_NOT]),
      .IncPC(ov[INCPC]),
      .Read(ov[READ]),
      .read_mem(ov[RDMEM]),
      .write_mem(ov[WRMEM]),
      .PCSave(ov[PCSAVE]),
      .CON_RESET(ov[CONRST]),
      .run(ov[RUN])
    );
  end

  assign o0 = g_dut[0].ov;
  assign o1 = g_dut[1].ov;

  function automatic vec_t obs(int w);
    return (w != 0) ? o1 : o0;
  endfunction

  function automatic int mrc_of(int w);
    return (w != 0) ? 3 : 1;
  endfunction

  function automatic vec_t b(int i);
    vec_t v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int alu_of(int op);
    case (op)
      3, 12:   return A_ADD;
      4:       return A_SUB;
      5, 13:   return A_AND;
      6, 14:   return A_OR;
      7:       return A_ROR;
      8:       return A_ROL;
      9:       return A_SHR;
      10:      return A_SHRA;
      11:      return A_SHL;
      15:      return A_DIV;
      16:      return A_MUL;
      17:      return A_NEG;
      default: return A_NOT;
    endcase
  endfunction

  // Expected strobe vector for every clock of one instruction,
  // starting at its T0 and ending at the following T0.
  function automatic void model(int op, bit c, int mrc);
    vec_t r   = b(RUN);
    vec_t t0  = r | b(INCPC) | b(MARIN) | b(PCIN);
    vec_t lt3 = r | b(GRB) | b(BAOUT) | b(YIN);
    vec_t lt4 = r | b(COUT) | b(A_ADD) | b(ZIN);
    vec_t wb  = r | b(ZLOOUT) | b(GRA) | b(RIN);
    exp_q.delete();
    exp_q.push_back(t0);
    for (int i = 0; i < mrc; i++)
      exp_q.push_back(r | b(READ) | b(RDMEM) | b(MDRIN));
    exp_q.push_back(r | b(READ) | b(MDROUT) | b(IRIN));
    if (op >= 3 && op <= 11) begin
      exp_q.push_back(r | b(GRB) | b(ROUT) | b(YIN));
      exp_q.push_back(r | b(GRC) | b(ROUT) | b(alu_of(op)) | b(ZIN));
      exp_q.push_back(wb);
    end else if (op == 17 || op == 18) begin
      exp_q.push_back(r | b(GRB) | b(ROUT) | b(alu_of(op)) | b(ZIN));
      exp_q.push_back(wb);
    end else if (op >= 12 && op <= 14) begin
      exp_q.push_back(r | b(GRB) | b(ROUT) | b(YIN));
      exp_q.push_back(r | b(COUT) | b(alu_of(op)) | b(ZIN));
      exp_q.push_back(wb);
    end else if (op == 15 || op == 16) begin
      exp_q.push_back(r | b(GRA) | b(ROUT) | b(YIN));
      exp_q.push_back(r | b(GRB) | b(ROUT) | b(alu_of(op)) | b(ZIN));
      exp_q.push_back(r | b(ZLOOUT) | b(LOIN));
      exp_q.push_back(r | b(ZHIOUT) | b(HIIN));
    end else if (op == 1) begin
      exp_q.push_back(lt3);
      exp_q.push_back(lt4);
      exp_q.push_back(wb);
    end else if (op == 0) begin
      exp_q.push_back(lt3);
      exp_q.push_back(lt4);
      exp_q.push_back(r | b(ZLOOUT) | b(MARIN));
      for (int i = 0; i < mrc; i++)
        exp_q.push_back(r | b(READ) | b(RDMEM) | b(MDRIN));
      exp_q.push_back(r | b(MDROUT) | b(GRA) | b(RIN));
    end else if (op == 2) begin
      exp_q.push_back(lt3);
      exp_q.push_back(lt4);
      exp_q.push_back(r | b(ZLOOUT) | b(MARIN));
      exp_q.push_back(r | b(GRA) | b(ROUT) | b(MDRIN));
      for (int i = 0; i < mrc; i++)
        exp_q.push_back(r | b(WRMEM));
    end else if (op == 19) begin
      exp_q.push_back(r | b(GRA) | b(ROUT) | b(CONIN));
      exp_q.push_back(r | b(PCOUT) | b(YIN));
      exp_q.push_back(r | b(COUT) | b(A_ADD) | b(ZIN));
      exp_q.push_back(c ? (r | b(ZLOOUT) | b(PCIN)) : r);
    end else if (op == 20) begin
      exp_q.push_back(r | b(GRA) | b(ROUT) | b(PCIN));
    end else if (op == 21) begin
      exp_q.push_back(r | b(PCSAVE) | b(PCOUT) | b(RIN));
      exp_q.push_back(r | b(GRA) | b(ROUT) | b(PCIN));
    end else if (op == 22) begin
      exp_q.push_back(r | b(INOUT) | b(GRA) | b(RIN));
    end else if (op == 23) begin
      exp_q.push_back(r | b(GRA) | b(ROUT) | b(OUTPIN));
    end else if (op == 24) begin
      exp_q.push_back(r | b(HIOUT) | b(GRA) | b(RIN));
    end else if (op == 25) begin
      exp_q.push_back(r | b(LOOUT) | b(GRA) | b(RIN));
    end
    if (op == 27) begin
      for (int i = 0; i < 20; i++) exp_q.push_back('0);
    end else begin
      exp_q.push_back(t0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (2) tick();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== b(CONRST)) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want %h",
                 w, obs(w), b(CONRST));
      end
    end
    reset = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== b(CONRST)) begin
        errors++;
        $display("FAIL rst_state[%0d]: got %h want %h",
                 w, obs(w), b(CONRST));
      end
    end
    tick();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== (b(RUN) | b(INCPC) | b(MARIN) | b(PCIN))) begin
        errors++;
        $display("FAIL first_t0[%0d]: got %h", w, obs(w));
      end
    end
  endtask

  task automatic test_ldi();
    reset_dut();
    ir[0] = 32'h09800065;
    model(1, 1'b0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      checks++;
      if (o0 !== exp_q[i]) begin
        errors++;
        $display("FAIL ldi[%0d]: got %h want %h", i, o0, exp_q[i]);
      end
    end
  endtask

  task automatic test_add_wait3();
    int rd = 0;
    reset_dut();
    ir[1] = 32'h18918000;
    model(3, 1'b0, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      if (o1[READ] && o1[MDRIN]) rd++;
      checks++;
      if (o1 !== exp_q[i]) begin
        errors++;
        $display("FAIL add3[%0d]: got %h want %h", i, o1, exp_q[i]);
      end
    end
    checks++;
    if (rd != 3) begin
      errors++;
      $display("FAIL t1_hold: got %0d clocks want 3", rd);
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 2; c++) begin
      reset_dut();
      ir[0]  = 32'h98000000;
      con[0] = c[0];
      model(19, c[0], 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (o0 !== exp_q[i]) begin
          errors++;
          $display("FAIL br%0d[%0d]: got %h want %h",
                   c, i, o0, exp_q[i]);
        end
        if (i == 6) begin
          checks++;
          if (o0[PCIN] !== c[0]) begin
            errors++;
            $display("FAIL br_pcin: got %b want %b", o0[PCIN], c[0]);
          end
        end
      end
    end
    con[0] = 1'b0;
  endtask

  task automatic test_jal();
    reset_dut();
    ir[0] = 32'hAA800000;
    model(21, 1'b0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      checks++;
      if (o0 !== exp_q[i]) begin
        errors++;
        $display("FAIL jal[%0d]: got %h want %h", i, o0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    logic [4:0]  op;
    int          mrc;
    for (int w = 0; w < 2; w++) begin
      reset_dut();
      mrc = mrc_of(w);
      repeat (40) begin
        op  = 5'($urandom_range(0, 31));
        if (op == 5'd27) op = 5'd26;
        rnd = $urandom();
        ir[w]  = {op, rnd[26:0]};
        con[w] = 1'($urandom_range(0, 1));
        model(int'(op), con[w], mrc);
        for (int i = 0; i < exp_q.size(); i++) begin
          if (i > 0) tick();
          checks++;
          if (obs(w) !== exp_q[i]) begin
            errors++;
            $display("FAIL rand op%0d[%0d]: got %h want %h",
                     op, i, obs(w), exp_q[i]);
          end
          if (i == mrc + 2) ir[w] = $urandom();
        end
      end
    end
  endtask

  task automatic test_halt();
    reset_dut();
    ir[0] = 32'hD8000000;
    model(27, 1'b0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      checks++;
      if (o0 !== exp_q[i]) begin
        errors++;
        $display("FAIL halt[%0d]: got %h want %h", i, o0, exp_q[i]);
      end
    end
    ir[0] = 32'hD0000000;
    reset_dut();
    checks++;
    if (o0 !== (b(RUN) | b(INCPC) | b(MARIN) | b(PCIN))) begin
      errors++;
      $display("FAIL halt_recover: got %h", o0);
    end
  endtask

  task automatic test_st_abort();
    int wp = 0;
    reset_dut();
    ir[1] = 32'h10C00004;
    model(2, 1'b0, 3);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (o1 !== exp_q[i]) begin
        errors++;
        $display("FAIL st[%0d]: got %h want %h", i, o1, exp_q[i]);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (o1 !== b(CONRST)) begin
      errors++;
      $display("FAIL abort_rst: got %h want %h", o1, b(CONRST));
    end
    repeat (10) begin
      tick();
      if (o1[WRMEM]) wp++;
    end
    checks++;
    if (wp != 0) begin
      errors++;
      $display("FAIL no_write: got %0d write_mem clocks want 0", wp);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (o1 !== (b(RUN) | b(INCPC) | b(MARIN) | b(PCIN))) begin
      errors++;
      $display("FAIL abort_recover: got %h", o1);
    end
  endtask

  initial begin
    ir[0]  = 32'hD0000000;
    ir[1]  = 32'hD0000000;
    con[0] = 1'b0;
    con[1] = 1'b0;
    test_reset();
    test_ldi();
    test_add_wait3();
    test_branch();
    test_jal();
    test_random();
    test_halt();
    test_st_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
